// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry valid/ready pipeline stage (main + skid entry).
// Breaks the ready chain: in_ready depends only on held state and reset_n,
// never on out_ready. Sustains one transfer per cycle, and stalls upstream
// only when both entries are occupied.
// Optional feature macro: PIPE_SKID_STALL_COUNT_EN adds a saturating 16-bit
// stall_count output counting cycles where out_valid is held off by out_ready.
module pipe_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_COUNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             in_fire_s;
    logic             out_fire_s;

    // Handshake outputs decoded straight from registered state (and reset_n).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!reset_n) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end else begin
            in_ready  = (state_r != ST_FULL);
            out_valid = (state_r != ST_EMPTY);
        end
    end

    assign out_data   = main_r;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Occupancy FSM plus payload storage; the skid entry always refills main
    // before any new input so ordering stays strictly first-in first-out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
            main_r  <= '0;
            skid_r  <= '0;
        end else if (flush) begin
            // Only validity is dropped; payload registers keep stale contents
            // which are never shown because out_valid goes low.
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_r <= ST_BUSY;
                        main_r  <= in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        main_r <= in_data;
                    end else if (in_fire_s) begin
                        state_r <= ST_FULL;
                        skid_r  <= in_data;
                    end else if (out_fire_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_r <= ST_BUSY;
                        main_r  <= skid_r;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_COUNT_EN
    logic [15:0] stall_count_r;

    // Saturating count of cycles a valid output is held by downstream
    // backpressure; flush does not clear it, only reset_n does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= 16'd0;
        end else if (out_valid && !out_ready && !flush && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand-written
// reset/streaming sequences, and randomized traffic against a queue model.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_skid_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef PIPE_SKID_STALL_COUNT_EN
        check("rst_stall_count", {16'd0, stall_count}, 32'd0);
`endif
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    vec_t        vecs[14];
    logic [31:0] q[$];

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        #2;
        do_reset();

        // Directed table: backpressure, simultaneous fire, flush in FULL/BUSY.
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 32'h0000_000A};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'h0000_000A};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 32'h0000_000A};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 32'h0000_000B};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_000C};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b1, 1'b1, 32'h0000_000C};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_000D, 1'b0, 1'b0, 1'b1, 32'h0000_000C};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_000E, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_000E};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0021, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 1'b1, 32'h0000_0021};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            end
            tick();
        end

        // Streaming 1..8 with out_ready held high: one-cycle latency, no stalls.
        for (int k = 0; k <= 8; k++) begin
            drive(1'b0, (k < 8), k + 1, 1'b1);
            #1;
            check($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            check($sformatf("stream%0d_out_valid", k), {31'd0, out_valid}, (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check($sformatf("stream%0d_out_data", k), out_data, k);
            end
            tick();
        end

        // Reset asserted mid-stream with both entries occupied.
        drive(1'b0, 1'b1, 32'h0000_0055, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0066, 1'b0);
        tick();
        #2;
        do_reset();

        // Randomized traffic against a two-deep FIFO model.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic fl, iv, ordy, e_ir, e_ov, in_f, out_f;
            logic [31:0] d;
            fl   = ($urandom_range(0, 19) == 0);
            iv   = $urandom_range(0, 1);
            ordy = ($urandom_range(0, 2) != 0);
            d    = $urandom;
            drive(fl, iv, d, ordy);
            #1;
            e_ir = (q.size() < 2);
            e_ov = (q.size() > 0);
            check("rand_in_ready", {31'd0, in_ready}, {31'd0, e_ir});
            check("rand_out_valid", {31'd0, out_valid}, {31'd0, e_ov});
            if (e_ov) begin
                check("rand_out_data", out_data, q[0]);
            end
            in_f  = iv & e_ir;
            out_f = e_ov & ordy;
            if (fl) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(d);
            end
            tick();
        end

`ifdef PIPE_SKID_STALL_COUNT_EN
        // Stall counter saturation, flush retention, reset clear.
        do_reset();
        drive(1'b0, 1'b1, 32'h0000_0077, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        for (int s = 0; s < 5; s++) tick();
        check("stall_count_5", {16'd0, stall_count}, 32'd5);
        for (int s = 0; s < 70000; s++) tick();
        check("stall_count_sat", {16'd0, stall_count}, 32'h0000_FFFF);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        check("stall_count_flush", {16'd0, stall_count}, 32'h0000_FFFF);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
